// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced key levels to press/release/long/repeat event pulses
// Optional auto-repeat is built when KEY_REPEAT_EN is defined; otherwise key_rpt is constant 0.
module key_event_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic [3:0] key_rpt,
    output logic       key_evt,
    output logic [1:0] key_code
);
    localparam int DIV     = CLK_HZ / 1000;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [3:0]    r_s1, r_s2, r_s3;
    logic [PW-1:0] r_pre;
    logic          w_tick;
    logic [3:0]    w_fall, w_rise;
    state_t        r_state    [4];
    state_t        w_state_nx [4];
    logic [CW-1:0] r_cnt      [4];
    logic [CW-1:0] w_cnt_nx   [4];
    logic [3:0]    w_press_nx, w_rel_nx, w_long_nx, w_rpt_nx, w_any;
    logic [1:0]    w_code_nx;
    logic [3:0]    r_press, r_rel, r_long, r_rpt;
    logic          r_evt;
    logic [1:0]    r_code;

    // Synchroniser resets to "released" so a key held through reset yields a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 4'hF;
            r_s2 <= 4'hF;
            r_s3 <= 4'hF;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_fall = ~r_s2 & r_s3;
    assign w_rise = r_s2 & ~r_s3;
    assign w_tick = (r_pre == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= IDLE;
                r_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= w_state_nx[k];
                r_cnt[k]   <= w_cnt_nx[k];
            end
        end
    end

    // Release is checked first in every held state so it suppresses a same-cycle long/repeat.
    always_comb begin
        w_press_nx = '0;
        w_rel_nx   = '0;
        w_long_nx  = '0;
        w_rpt_nx   = '0;
        for (int k = 0; k < 4; k++) begin
            w_state_nx[k] = r_state[k];
            w_cnt_nx[k]   = r_cnt[k];
            case (r_state[k])
                IDLE: begin
                    if (w_fall[k]) begin
                        w_press_nx[k] = 1'b1;
                        w_state_nx[k] = HELD;
                        w_cnt_nx[k]   = '0;
                    end
                end
                HELD: begin
                    if (w_rise[k]) begin
                        w_rel_nx[k]   = 1'b1;
                        w_state_nx[k] = IDLE;
                        w_cnt_nx[k]   = '0;
                    end else if (w_tick) begin
                        if (r_cnt[k] == CW'(LONG_MS - 1)) begin
                            w_long_nx[k]  = 1'b1;
                            w_state_nx[k] = LONG;
                            w_cnt_nx[k]   = '0;
                        end else begin
                            w_cnt_nx[k] = r_cnt[k] + 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (w_rise[k]) begin
                        w_rel_nx[k]   = 1'b1;
                        w_state_nx[k] = IDLE;
                        w_cnt_nx[k]   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (w_tick) begin
                        if (r_cnt[k] == CW'(REPEAT_MS - 1)) begin
                            w_rpt_nx[k] = 1'b1;
                            w_cnt_nx[k] = '0;
                        end else begin
                            w_cnt_nx[k] = r_cnt[k] + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    w_state_nx[k] = IDLE;
                    w_cnt_nx[k]   = '0;
                end
            endcase
        end
    end

    assign w_any = w_press_nx | w_rel_nx | w_long_nx | w_rpt_nx;

    // Scan downward so the lowest active index is the one left standing.
    always_comb begin
        w_code_nx = r_code;
        for (int k = 3; k >= 0; k--) begin
            if (w_any[k]) begin
                w_code_nx = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press <= '0;
            r_rel   <= '0;
            r_long  <= '0;
            r_rpt   <= '0;
            r_evt   <= 1'b0;
            r_code  <= '0;
        end else begin
            r_press <= w_press_nx;
            r_rel   <= w_rel_nx;
            r_long  <= w_long_nx;
            r_rpt   <= w_rpt_nx;
            r_evt   <= |w_any;
            r_code  <= w_code_nx;
        end
    end

    assign key_press   = r_press;
    assign key_release = r_rel;
    assign key_long    = r_long;
    assign key_rpt     = r_rpt;
    assign key_evt     = r_evt;
    assign key_code    = r_code;
endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - self-checking bench for key_event_gen (CLK_HZ=10k, LONG_MS=5, REPEAT_MS=2)
module tb_key_event_gen;
    localparam int CLK_HZ    = 10_000;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 2;
    localparam int DIV       = CLK_HZ / 1000;
`ifdef KEY_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_press, key_release, key_long, key_rpt;
    logic       key_evt;
    logic [1:0] key_code;

    key_event_gen #(.CLK_HZ(CLK_HZ), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_press(key_press), .key_release(key_release), .key_long(key_long),
        .key_rpt(key_rpt), .key_evt(key_evt), .key_code(key_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: key levels seen by the design lag by two edges; a held key counts ms ticks
    // since its press, long fires on the LONG_MS-th tick, repeats every REPEAT_MS ticks after.
    logic [3:0] h0, h1, h2;
    bit         held [4];
    int         nticks [4];
    int         ecnt;
    logic [3:0] m_press, m_rel, m_long, m_rpt;
    logic       m_evt;
    logic [1:0] m_code;

    task automatic model_reset();
        h0 = 4'hF; h1 = 4'hF; h2 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            held[i] = 0;
            nticks[i] = 0;
        end
        ecnt = 0;
        m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0; m_evt = 0; m_code = '0;
    endtask

    task automatic model_edge();
        bit tick;
        ecnt++;
        tick = (ecnt % DIV) == 0;
        m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
        for (int i = 0; i < 4; i++) begin
            if (held[i] && h1[i] && !h2[i]) begin
                m_rel[i] = 1'b1;
                held[i] = 0;
            end else if (!held[i] && !h1[i] && h2[i]) begin
                m_press[i] = 1'b1;
                held[i] = 1;
                nticks[i] = 0;
            end else if (held[i] && tick) begin
                nticks[i]++;
                if (nticks[i] == LONG_MS)
                    m_long[i] = 1'b1;
                else if (RPT_EN && nticks[i] > LONG_MS && ((nticks[i] - LONG_MS) % REPEAT_MS) == 0)
                    m_rpt[i] = 1'b1;
            end
        end
        m_evt = |(m_press | m_rel | m_long | m_rpt);
        for (int i = 3; i >= 0; i--)
            if (m_press[i] | m_rel[i] | m_long[i] | m_rpt[i]) m_code = 2'(i);
        h2 = h1; h1 = h0; h0 = key_in;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, ecnt, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, key_press, key_release, key_long, key_rpt, key_evt, key_code};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", outs(), {13'd0, m_press, m_rel, m_long, m_rpt, m_evt, m_code});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("reset_hold", outs(), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
        int         exp_long;
        logic [1:0] exp_code;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [3:0] acc_p, acc_r;
        int         nlong, nev;

        tbl[0] = '{4'b1011, 30,  4'b0100, 4'b0100, 0, 2'd2};
        tbl[1] = '{4'b0101, 20,  4'b1010, 4'b1010, 0, 2'd1};
        tbl[2] = '{4'b1110, 200, 4'b0001, 4'b0001, 1, 2'd0};
        tbl[3] = '{4'b0111, 60,  4'b1000, 4'b1000, 1, 2'd3};
        tbl[4] = '{4'b0000, 10,  4'b1111, 4'b1111, 0, 2'd0};

        // Reset, then a quiet idle stretch
        model_reset();
        key_in = 4'hF;
        do_reset();
        nev = 0;
        repeat (100) begin
            step();
            if (key_evt) nev++;
        end
        check("idle_no_events", nev, 0);

        // Press latency: pulse on exactly the 3rd edge after the fall
        key_in = 4'b1011;
        step(); check("lat_edge1", key_press, 4'b0000);
        step(); check("lat_edge2", key_press, 4'b0000);
        step(); check("lat_edge3", {key_press, key_evt, key_code}, {4'b0100, 1'b1, 2'd2});
        step(); check("press_one_clk", key_press, 4'b0000);
        key_in = 4'hF;
        repeat (20) step();

        // Table of press/hold/release scenarios
        foreach (tbl[t]) begin
            acc_p = '0; acc_r = '0; nlong = 0;
            key_in = tbl[t].keys;
            repeat (tbl[t].hold) begin
                step();
                acc_p |= key_press; acc_r |= key_release; nlong += $countones(key_long);
            end
            key_in = 4'hF;
            repeat (70) begin
                step();
                acc_p |= key_press; acc_r |= key_release; nlong += $countones(key_long);
            end
            check($sformatf("tbl%0d_press", t), acc_p, tbl[t].exp_press);
            check($sformatf("tbl%0d_release", t), acc_r, tbl[t].exp_rel);
            check($sformatf("tbl%0d_long", t), nlong, tbl[t].exp_long);
            check($sformatf("tbl%0d_code", t), key_code, tbl[t].exp_code);
        end

        // Release edge lands on the tick that would fire long: press at edge 3, tick at 50
        do_reset();
        key_in = 4'b1110;
        while (ecnt < 47) step();
        key_in = 4'hF;
        while (ecnt < 50) step();
        check("thresh_release", {key_release, key_long}, {4'b0001, 4'b0000});
        nlong = 0;
        repeat (60) begin
            step();
            nlong += $countones(key_long);
        end
        check("thresh_no_long", nlong, 0);

        // Reset while in LONG, key kept low through reset
        do_reset();
        key_in = 4'b0111;
        while (ecnt < 50) step();
        check("long_at_50", {key_long, key_code}, {4'b1000, 2'd3});
        repeat (15) step();
        while (ecnt % DIV != 0) step();
        rst_n = 1'b0;
        #1;
        check("midrun_async_reset", outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        step(); step();
        check("rearm_edge2", key_press, 4'b0000);
        step();
        check("rearm_press", {key_press, key_code}, {4'b1000, 2'd3});
        while (ecnt < 50) step();
        check("rearm_long", key_long, 4'b1000);
        key_in = 4'hF;
        repeat (30) step();

        // Randomised key patterns against the reference
        for (int r = 0; r < 40; r++) begin
            key_in = 4'($urandom);
            repeat ($urandom_range(1, 70)) step();
        end
        key_in = 4'hF;
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
